controle_valvulas_multi: RTL
============================

# controle_valvulas_multi

Multi-channel valve sequencer, successor to the single-valve fixed-60 s controller. Drives `N_CH` valves, each with a duration programmed per start and counted in ms ticks. Supports per-channel abort and caps simultaneously open valves at `MAX_OPEN` (supply/pump current limit) with lowest-index-first arbitration. Sits between the main brewing FSM and the valve output pins.

## Interface
- `N_CH`, 4: number of valve channels.
- `MAX_OPEN`, 2: maximum valves open at once; 1 ≤ `MAX_OPEN` ≤ `N_CH`.
- `TICK_DIV`, 50000: clock cycles per tick (1 ms at 50 MHz).
- `DUR_W`, 16: duration width in ticks.

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `liga_valvula`  in  N_CH  per-channel start pulse.
- `para_valvula`  in  N_CH  per-channel abort, level or pulse.
- `duracao`  in  N_CH*DUR_W  flattened durations in ticks; channel i is bits [i*DUR_W +: DUR_W]. Sampled on an accepted start.
- `valvula`  out  N_CH  valve drive, registered.
- `fim_valvula`  out  N_CH  1-cycle pulse on natural completion.
- `abortado`  out  N_CH  1-cycle pulse when a pending or open channel is aborted.
- `ocupado`  out  N_CH  channel is pending or open.

## Operation
- Reset value of every output is 0. All channels are IDLE, the prescaler is 0 and the remaining counters are 0.
- Per-channel FSM:
  - IDLE: `liga_valvula[i]` with `duracao[i]`≠0 → PEND, latching the duration. With `duracao[i]`=0 → stays IDLE and pulses `fim_valvula[i]` next cycle; no slot is used.
  - PEND: on grant → OPEN; `para_valvula[i]` → IDLE and pulses `abortado[i]`.
  - OPEN: `valvula[i]`=1. On each tick, remaining decrements. On the tick where remaining==1 → IDLE and pulses `fim_valvula[i]`. `para_valvula[i]` → IDLE and pulses `abortado[i]`.
- `liga_valvula[i]` while the channel is in PEND or OPEN is ignored; there is no restart or extension.
- If abort and start arrive in the same cycle, abort wins. If abort and final tick arrive in the same cycle, abort wins: `abortado` pulses and `fim_valvula` does not.
- `ocupado[i]` = (state ∈ {PEND, OPEN}).
- Arbiter, evaluated every cycle:
  - free = `MAX_OPEN` − (count of OPEN channels).
  - Grant up to `free` PEND channels, lowest index first.
  - A channel closing in cycle t frees its slot for the grant evaluation in cycle t+1.
- Prescaler: a single free-running counter shared by all channels, 0..`TICK_DIV`−1. A tick is a 1-cycle strobe when the counter wraps. Ticks are not aligned to the start.

## Timing
- Start accepted at edge t with a slot free: grant is combinational at t, so `valvula[i]`=1 from t+1 and `ocupado[i]`=1 from t+1.
- Start into PEND: `ocupado` rises at t+1. `valvula` rises one cycle after the grant cycle.
- Open time for duration D: between (D−1)·`TICK_DIV`+1 and D·`TICK_DIV` cycles.
- `valvula` falls on the same edge `fim_valvula` rises. `fim_valvula` is high for exactly 1 cycle.
- Abort seen at edge t: `valvula`/`ocupado` fall at t+1 and `abortado` is high for cycle t+1 only.
- Asynchronous reset mid-operation closes all valves immediately, with no `fim` or `abortado` pulses. Pending requests are lost.
- At most `MAX_OPEN` bits of `valvula` are ever high in any cycle. This is a checked invariant.

## Structure
- Package `valvula_pkg`:
  - state enum `{IDLE, PEND, OPEN}`;
  - default `TICK_DIV`;
  - a `$clog2`-based width helper for the open-count and prescaler.
- Sub-module `canal_valvula`: one per channel via generate. Contains the FSM, latched remaining counter, and output pulse registers. Inputs are `grant`, `tick`, start, abort and duration.
- The top holds the prescaler, the popcount of OPEN channels, and the priority grant loop.
- Expected size: ~80 lines for the channel, ~120 for the top.

## Test plan
Bench settings: `N_CH`=4, `MAX_OPEN`=2, `TICK_DIV`=10, `DUR_W`=8.

1. Start ch0 with D=3 → `valvula[0]` high 21–30 cycles, then `fim_valvula[0]` pulses once, `ocupado[0]` drops.
2. Start ch0–ch3 together with D=2 each → ch0/ch1 open at t+1, ch2/ch3 PEND. ch2/ch3 open one cycle after ch0/ch1 close. Never more than 2 `valvula` bits high.
3. Abort ch1 mid-OPEN with D=5 → `valvula[1]` low next cycle, `abortado[1]` 1-cycle pulse, no `fim_valvula[1]`. Freed slot granted to pending ch2 the cycle after.
4. D=0 start on ch3 → `valvula[3]` never rises, `fim_valvula[3]` pulses at t+1.
5. Same-cycle abort + final tick on ch0 → `abortado[0]` only. Re-issue `liga_valvula[0]` while OPEN → ignored, close time unchanged.
6. Assert `reset`=0 with two valves open → all outputs 0 asynchronously. After release, start ch2 with D=1 → normal single-tick cycle.

Source files
------------

// File: rtl/valvula_pkg.sv
// -----------------------------------------------------------------------------
// valvula_pkg
// Shared definitions for the multi-channel valve sequencer:
//   - estado_t        : per-channel state (IDLE / PEND / OPEN)
//   - TICK_DIV_PADRAO : default clock cycles per ms tick (50 MHz clock)
//   - largura()       : bit width needed to hold the values 0..valor-1
// -----------------------------------------------------------------------------
package valvula_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      OPEN = 2'd2
   } estado_t;

   localparam int TICK_DIV_PADRAO = 50000;

   // Width of a counter that must represent 0..valor-1 (never narrower than 1).
   function automatic int largura(input int valor);
      return (valor <= 1) ? 1 : $clog2(valor);
   endfunction

endpackage

// File: rtl/canal_valvula.sv
// -----------------------------------------------------------------------------
// canal_valvula
// One valve channel: IDLE/PEND/OPEN state machine, the remaining-tick counter
// latched on an accepted start, and the registered valve/pulse outputs.
//
// Ports:
//   clock, reset   system clock, asynchronous active-low reset
//   grant_i        slot granted by the top-level arbiter (valid with req_o)
//   tick_i         1-cycle ms strobe from the shared prescaler
//   liga_i         start pulse
//   para_i         abort (level or pulse); wins over start and final tick
//   duracao_i      duration in ticks, sampled on an accepted start
//   req_o          channel wants a slot this cycle (pending or fresh start)
//   aberto_o       channel currently OPEN (feeds the arbiter's popcount)
//   valvula_o      registered valve drive
//   fim_o          1-cycle pulse on natural completion (or zero-length start)
//   abortado_o     1-cycle pulse when a pending/open channel is aborted
//   ocupado_o      channel is pending or open
// -----------------------------------------------------------------------------
module canal_valvula
   import valvula_pkg::*;
#(
   parameter int DUR_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             grant_i,
   input  logic             tick_i,
   input  logic             liga_i,
   input  logic             para_i,
   input  logic [DUR_W-1:0] duracao_i,
   output logic             req_o,
   output logic             aberto_o,
   output logic             valvula_o,
   output logic             fim_o,
   output logic             abortado_o,
   output logic             ocupado_o
);

   estado_t          estado_q, estado_d;
   logic [DUR_W-1:0] resta_q, resta_d;
   logic             valvula_q, fim_q, fim_d, abortado_q, abortado_d;

   logic aceita;       // start with a non-zero duration, not overridden by abort
   logic aceita_zero;  // zero-length start: completes at once, never takes a slot
   logic ultimo_tick;  // this tick consumes the last remaining tick

   assign aceita      = liga_i && !para_i && (duracao_i != '0);
   assign aceita_zero = liga_i && !para_i && (duracao_i == '0);
   assign ultimo_tick = tick_i && (resta_q == DUR_W'(1));

   // A fresh start competes in the same cycle, so an accepted start with a
   // free slot opens the valve on the very next edge. An aborting channel
   // does not request, so it never wastes a slot another channel could use.
   always_comb begin
      req_o = 1'b0;
      unique case (estado_q)
         IDLE:    req_o = aceita;
         PEND:    req_o = !para_i;
         default: req_o = 1'b0;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= IDLE;
         resta_q  <= '0;
      end else begin
         estado_q <= estado_d;
         resta_q  <= resta_d;
      end
   end

   // Next-state logic.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      estado_d = estado_q;
      resta_d  = resta_q;
      unique case (estado_q)
         IDLE: begin
            if (aceita) begin
               resta_d  = duracao_i;
               estado_d = grant_i ? OPEN : PEND;
            end
         end
         PEND: begin
            if (para_i) begin
               estado_d = IDLE;
               resta_d  = '0;
            end else if (grant_i) begin
               estado_d = OPEN;
            end
         end
         OPEN: begin
            if (para_i) begin
               estado_d = IDLE;
               resta_d  = '0;
            end else if (tick_i) begin
               resta_d = resta_q - DUR_W'(1);
               if (ultimo_tick) estado_d = IDLE;
            end
         end
         default: begin
            estado_d = IDLE;
            resta_d  = '0;
         end
      endcase
   end

   // Output logic: pulse requests for the next cycle. Abort beats the final
   // tick, so completion is only reported when no abort is present.
   always_comb begin
      fim_d      = 1'b0;
      abortado_d = 1'b0;
      unique case (estado_q)
         IDLE: fim_d = aceita_zero;
         PEND: abortado_d = para_i;
         OPEN: begin
            abortado_d = para_i;
            fim_d      = !para_i && ultimo_tick;
         end
         default: begin
            fim_d      = 1'b0;
            abortado_d = 1'b0;
         end
      endcase
   end

   // Registered outputs: the valve drive follows the next state so it changes
   // on the same edge as the state and the completion/abort pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valvula_q  <= 1'b0;
         fim_q      <= 1'b0;
         abortado_q <= 1'b0;
      end else begin
         valvula_q  <= (estado_d == OPEN);
         fim_q      <= fim_d;
         abortado_q <= abortado_d;
      end
   end

   assign valvula_o  = valvula_q;
   assign fim_o      = fim_q;
   assign abortado_o = abortado_q;
   assign ocupado_o  = (estado_q != IDLE);
   assign aberto_o   = (estado_q == OPEN);

endmodule

// File: rtl/controle_valvulas_multi.sv
// -----------------------------------------------------------------------------
// controle_valvulas_multi
// Multi-channel valve sequencer. Each channel opens its valve for a duration
// (in ms ticks) given with its start pulse; at most MAX_OPEN valves are open
// at once, with free slots granted lowest channel index first.
//
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   liga_valvula  per-channel start pulse
//   para_valvula  per-channel abort (level or pulse)
//   duracao       flattened durations, channel i at [i*DUR_W +: DUR_W]
//   valvula       registered valve drive
//   fim_valvula   1-cycle pulse on natural completion
//   abortado      1-cycle pulse when a pending or open channel is aborted
//   ocupado       channel pending or open
// -----------------------------------------------------------------------------
module controle_valvulas_multi
   import valvula_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int MAX_OPEN = 2,
   parameter int TICK_DIV = TICK_DIV_PADRAO,
   parameter int DUR_W    = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [N_CH-1:0]       liga_valvula,
   input  logic [N_CH-1:0]       para_valvula,
   input  logic [N_CH*DUR_W-1:0] duracao,
   output logic [N_CH-1:0]       valvula,
   output logic [N_CH-1:0]       fim_valvula,
   output logic [N_CH-1:0]       abortado,
   output logic [N_CH-1:0]       ocupado
);

   localparam int CNT_W = largura(N_CH + 1);
   localparam int PRE_W = largura(TICK_DIV);

   logic [PRE_W-1:0] presc_q, presc_d;
   logic             tick;
   logic [N_CH-1:0]  req, grant, aberto;
   logic [CNT_W-1:0] n_abertos, livres, n_concedidos;

   // Free-running ms prescaler shared by all channels; ticks are therefore
   // not aligned to any individual start.
   assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

   always_comb begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) presc_q <= '0;
      else        presc_q <= presc_d;
   end

   // Slots in use come from the registered OPEN states, so a channel closing
   // on an edge only releases its slot for the following cycle's grants.
   always_comb begin
      n_abertos = '0;
      for (int i = 0; i < N_CH; i++) begin
         n_abertos = n_abertos + CNT_W'(aberto[i]);
      end
      livres = CNT_W'(MAX_OPEN) - n_abertos;
   end

   // Priority grant: walk channels from index 0 and hand out free slots.
   always_comb begin
      grant        = '0;
      n_concedidos = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (req[i] && (n_concedidos < livres)) begin
            grant[i]     = 1'b1;
            n_concedidos = n_concedidos + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_canal
      canal_valvula #(
         .DUR_W (DUR_W)
      ) u_canal (
         .clock      (clock),
         .reset      (reset),
         .grant_i    (grant[g]),
         .tick_i     (tick),
         .liga_i     (liga_valvula[g]),
         .para_i     (para_valvula[g]),
         .duracao_i  (duracao[g*DUR_W +: DUR_W]),
         .req_o      (req[g]),
         .aberto_o   (aberto[g]),
         .valvula_o  (valvula[g]),
         .fim_o      (fim_valvula[g]),
         .abortado_o (abortado[g]),
         .ocupado_o  (ocupado[g])
      );
   end

   // Supply current limit: never more than MAX_OPEN valves driven at once.
   a_max_open : assert property (@(posedge clock) disable iff (!reset)
      $countones(valvula) <= MAX_OPEN);

endmodule
